// File: rtl/decada_pkg.sv
// Shared types and constants for the BCD decade counter: digit/segment
// widths, the BCD digit type and the active-low 7-segment patterns
// (bit order gfedcba, DE2-style).
package decada_pkg;

  localparam int BCD_W = 4;
  localparam int SEG_W = 7;

  typedef logic [BCD_W-1:0] bcd_digit_t;
  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment decoder.
// Non-BCD codes (10..15) show a blank digit.
module bcd_to_7seg
  import decada_pkg::*;
(
  input  bcd_digit_t digit,
  output seg_t       seg
);

  // Table lookup; anything outside 0..9 blanks the digit
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/contador_decada_bcd.sv
// Multi-digit BCD up/down decade counter stepped by rising edges of a slow
// square wave sampled in the clock_50 domain. Drives registered active-low
// 7-segment outputs and a one-cycle wrap pulse for cascading.
// Optional build macro LEADING_ZERO_BLANK_EN: blanks leading zero digits
// (digit 0 always shown); bcd and carry are unaffected by it.
module contador_decada_bcd
  import decada_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic                      clock_50,
  input  logic                      reset,
  input  logic                      tick_in,
  input  logic                      enable,
  input  logic                      up_down,
  input  logic                      load,
  input  logic [BCD_W*DIGITS-1:0]   load_value,
  output logic [BCD_W*DIGITS-1:0]   bcd,
  output logic [SEG_W*DIGITS-1:0]   hex,
  output logic                      carry
);

  // One digit step: returns {ripple_out, new_digit}
  function automatic logic [BCD_W:0] digit_step(input bcd_digit_t d, input logic up);
    if (up)
      return (d == 4'd9) ? {1'b1, 4'd0} : {1'b0, d + 4'd1};
    else
      return (d == 4'd0) ? {1'b1, 4'd9} : {1'b0, d - 4'd1};
  endfunction

  // Force any non-BCD digit on load back to zero
  function automatic bcd_digit_t digit_clamp(input bcd_digit_t d);
    return (d > 4'd9) ? 4'd0 : d;
  endfunction

  logic [SYNC_STAGES-1:0]    sync_p0;
  logic                      prev_p1;
  logic                      vld_p1;
  logic [BCD_W*DIGITS-1:0]   bcd_p2;
  logic [BCD_W*DIGITS-1:0]   bcd_step;
  logic [BCD_W*DIGITS-1:0]   bcd_load;
  logic                      wrap;
  logic                      carry_p2;
  logic [SEG_W*DIGITS-1:0]   seg_dec;
  logic [DIGITS-1:0]         blank;
  logic [SEG_W*DIGITS-1:0]   hex_nxt;
  logic [SEG_W*DIGITS-1:0]   hex_p3;

  // ---- stage 0: synchronizer; reset to 1 so a high tick_in at release is not an edge
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) sync_p0 <= '1;
    else       sync_p0 <= {sync_p0[SYNC_STAGES-2:0], tick_in};
  end

  // ---- stage 1: edge detect, one-cycle step strobe per rising edge
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) prev_p1 <= 1'b1;
    else       prev_p1 <= sync_p0[SYNC_STAGES-1];
  end

  assign vld_p1 = sync_p0[SYNC_STAGES-1] & ~prev_p1;

  // Ripple the increment/borrow through all digits in one cycle; sanitize load data
  always_comb begin
    logic           rip;
    logic [BCD_W:0] res;
    rip      = 1'b1;
    res      = '0;
    bcd_step = bcd_p2;
    bcd_load = '0;
    for (int i = 0; i < DIGITS; i++) begin
      res = digit_step(bcd_p2[BCD_W*i +: BCD_W], up_down);
      if (rip) bcd_step[BCD_W*i +: BCD_W] = res[BCD_W-1:0];
      rip = rip & res[BCD_W];
      bcd_load[BCD_W*i +: BCD_W] = digit_clamp(load_value[BCD_W*i +: BCD_W]);
    end
    wrap = rip;
  end

  // ---- stage 2: count register; load beats a step, disabled steps are dropped
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      bcd_p2   <= '0;
      carry_p2 <= 1'b0;
    end else if (load) begin
      bcd_p2   <= bcd_load;
      carry_p2 <= 1'b0;
    end else if (vld_p1 && enable) begin
      bcd_p2   <= bcd_step;
      carry_p2 <= wrap;
    end else begin
      carry_p2 <= 1'b0;
    end
  end

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dec
      bcd_to_7seg u_dec (
        .digit (bcd_p2[BCD_W*g +: BCD_W]),
        .seg   (seg_dec[SEG_W*g +: SEG_W])
      );
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  // A digit above 0 is blank when it and every higher digit are zero
  always_comb begin
    logic hi_zero;
    hi_zero = 1'b1;
    blank   = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero  = hi_zero & (bcd_p2[BCD_W*i +: BCD_W] == 4'd0);
      blank[i] = hi_zero;
    end
  end
`else
  assign blank = '0;
`endif

  // Choose decoded pattern or blank per digit
  always_comb begin
    hex_nxt = '0;
    for (int i = 0; i < DIGITS; i++)
      hex_nxt[SEG_W*i +: SEG_W] = blank[i] ? SEG_BLANK : seg_dec[SEG_W*i +: SEG_W];
  end

  // ---- stage 3: registered segment drive, one cycle behind bcd
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) hex_p3 <= {DIGITS{SEG_0}};
    else       hex_p3 <= hex_nxt;
  end

  assign bcd   = bcd_p2;
  assign carry = carry_p2;
  assign hex   = hex_p3;

endmodule

// File: doc/contador_decada_bcd.md
Name: contador_decada_bcd

Overview:
- Multi-digit BCD decade counter, directly downstream of the 50 MHz clock divider.
- Samples the divider's slow square-wave output as a data signal inside the clock_50 domain; no logic is clocked by the slow signal.
- Each rising edge of the slow signal is one count step, up or down, with load and enable controls.
- Drives per-digit 7-segment outputs (active-low, DE2-style) and a wrap pulse for cascading.

Parameters:
- DIGITS, 2, number of BCD digits; digit 0 is the least significant.
- SYNC_STAGES, 2, synchronizer flops on tick_in; legal values 2 to 4.

Ports:
- clock_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- tick_in  in  1  slow square wave from the divider; its rising edge is a count request.
- enable  in  1  1 = steps are applied; 0 = steps are discarded (pause).
- up_down  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous load strobe.
- load_value  in  4*DIGITS  BCD value to load; digit i is bits [4i+3:4i].
- bcd  out  4*DIGITS  current count, BCD.
- hex  out  7*DIGITS  segment drive, active-low, bit order gfedcba per digit.
- carry  out  1  one-cycle pulse on wrap: all-9 to all-0 going up, or all-0 to all-9 going down.

Behaviour:
- Reset (asynchronous, active-high):
  - bcd = 0; carry = 0.
  - hex = 7'b1000000 for every digit.
  - All synchronizer flops and the edge-detect "previous" flop are set to 1, so a tick_in held high across reset release does not produce a step.
- Edge detect:
  - step = sync_out & ~prev, where prev is the registered sync_out.
  - step is exactly one clock_50 cycle wide per tick_in rising edge.
- Latency:
  - tick_in rising edge to bcd update is SYNC_STAGES+1 cycles.
  - hex is registered and follows bcd by 1 cycle.
  - carry asserts in the same cycle bcd takes its wrapped value.
- Priority each cycle: reset > load > (step & enable) > hold.
- Load:
  - bcd takes load_value on the next edge.
  - Any digit > 9 is loaded as 0.
  - carry stays 0.
  - A step that coincides with load is lost.
- Up count:
  - Digit 0 increments.
  - A digit at 9 becomes 0 and propagates an increment to the next digit.
  - All digits at 9 become all 0, with carry = 1 for one cycle.
- Down count:
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and propagates a borrow to the next digit.
  - All digits at 0 become all 9, with carry = 1 for one cycle.
- Step while enable = 0: the step is discarded, not queued. bcd and carry are unchanged.
- up_down is sampled in the step cycle only. Changing it between steps takes effect on the next step.
- Digit arithmetic:
  - Each digit is a 4-bit field, always held in 0 to 9.
  - Carry and borrow chains are combinational across digits within one cycle.
- No state machine beyond the counter. The edge detector is the only sequencing element.
- Minimum tick_in high and low time is SYNC_STAGES+1 cycles. Narrower pulses may be missed; they are not required to count.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: for each digit i ≥ 1, hex digit i is blank (7'b1111111) when digit i and all higher digits are 0. Digit 0 is never blanked.
- Not defined: every digit always displays its value.
- bcd and carry behave identically in both builds.

Decomposition:
- Shared package (decada_pkg):
  - BCD_W = 4, SEG_W = 7.
  - Segment constants SEG_0 to SEG_9 and SEG_BLANK, active-low.
  - Typedef for one BCD digit, 4-bit.
- Sub-module bcd_to_7seg:
  - Combinational decode of 4 bits to 7 segments; inputs 10 to 15 give SEG_BLANK.
  - Instantiated DIGITS times.
  - Output registering is done in the top block.

Test Plan:
1. Reset with tick_in high, then release, then hold tick_in high for 100 cycles -> bcd = 8'h00, no step, hex = {7'b1000000, 7'b1000000}.
2. up_down = 1, enable = 1, 12 tick_in rising edges -> bcd = 8'h12; each update occurs exactly 3 cycles after its edge (SYNC_STAGES = 2).
3. load 8'h99, up_down = 1, one tick -> bcd = 8'h00 and carry high for exactly 1 cycle. Then up_down = 0, one tick -> bcd = 8'h99 and carry pulses again.
4. load 8'hA7 -> bcd = 8'h07. Load asserted in the same cycle as a step -> the step is lost and bcd equals load_value.
5. enable = 0 during 5 ticks -> bcd unchanged. enable = 1, one tick -> bcd increments by one only.
6. Assert reset mid-count at bcd = 8'h45 -> bcd = 0 and carry = 0 immediately, asynchronously. With LEADING_ZERO_BLANK_EN defined and bcd = 8'h05 -> hex = {7'b1111111, 7'b0010010}.
